// File: rtl/obi_addr_demux.sv
// obi_addr_demux: routes one OBI master onto NumSlaves OBI slaves by address.
// Requests to the same target may be pipelined up to MaxOutstanding deep.
// A request to a different target is held off until every outstanding
// response has come back, so responses always return in order.
//
// Optional feature macro: OBI_ADDR_DEMUX_ERR_RESP_EN
//   defined   -> unmapped accesses go to an internal error target that grants
//                at once and answers one cycle later with err_o=1, rdata_o=ErrData
//   undefined -> unmapped accesses are routed to slave port 0 and err_o is 0
//
// Handshake: a request transfers on the cycle where req_i and gnt_o are both
// high; a response transfers on the single cycle where rvalid_o is high
// (the master is always ready to accept a response).

package obi_addr_demux_pkg;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;   // exclusive
   } addr_map_rule_t;

   // Default system map. Rule 2 overlaps rule 1, so rule 1 wins unless it is
   // disabled through rule_en_i.
   localparam addr_map_rule_t [6:0] DefaultAddrMap = '{
      '{idx: 32'd6, start_addr: 32'h4000_0000, end_addr: 32'h4000_1000},  // GPIO
      '{idx: 32'd5, start_addr: 32'h3000_0000, end_addr: 32'h3000_1000},  // UART
      '{idx: 32'd4, start_addr: 32'h2000_0000, end_addr: 32'h2000_1000},  // PERIPH
      '{idx: 32'd3, start_addr: 32'h0001_0000, end_addr: 32'h0002_0000},  // ROM
      '{idx: 32'd2, start_addr: 32'h1000_0000, end_addr: 32'h1002_0000},  // RAM1
      '{idx: 32'd1, start_addr: 32'h1000_0000, end_addr: 32'h1001_0000},  // RAM0
      '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h0000_1000}   // DEBUG
   };

endpackage

module obi_addr_demux
   import obi_addr_demux_pkg::*;
#(
   parameter int unsigned                    NumSlaves      = 7,
   parameter int unsigned                    MaxOutstanding = 4,
   parameter addr_map_rule_t [NumSlaves-1:0] AddrRules      = DefaultAddrMap,
   parameter logic [31:0]                    ErrData        = 32'hBADACCE5
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NumSlaves-1:0]    rule_en_i,
   // master side
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [31:0]             addr_i,
   input  logic                    we_i,
   input  logic [3:0]              be_i,
   input  logic [31:0]             wdata_i,
   output logic                    rvalid_o,
   output logic [31:0]             rdata_o,
   output logic                    err_o,
   // slave side
   output logic [NumSlaves-1:0]    slv_req_o,
   input  logic [NumSlaves-1:0]    slv_gnt_i,
   output logic [31:0]             slv_addr_o,
   output logic                    slv_we_o,
   output logic [3:0]              slv_be_o,
   output logic [31:0]             slv_wdata_o,
   input  logic [NumSlaves-1:0]    slv_rvalid_i,
   input  logic [NumSlaves*32-1:0] slv_rdata_i
);

   localparam int unsigned TgtW = $clog2(NumSlaves + 1);
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   // Target code NumSlaves is the internal error target.
   localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumSlaves);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

   logic [TgtW-1:0] dec_tgt;
   logic [TgtW-1:0] tgt_q;
   logic [CntW-1:0] cnt_q;
   logic            stall;
   logic            grant;
   logic            rsp_valid;
   logic [31:0]     rsp_data;
   logic            err_rsp_q;

   // Payload is broadcast; only the selected slave sees a request.
   assign slv_addr_o  = addr_i;
   assign slv_we_o    = we_i;
   assign slv_be_o    = be_i;
   assign slv_wdata_o = wdata_i;

   // Address decode: lowest-numbered enabled rule containing addr_i wins.
   always_comb begin
      logic found;
      found = 1'b0;
`ifdef OBI_ADDR_DEMUX_ERR_RESP_EN
      dec_tgt = ErrTgt;
`else
      dec_tgt = '0;
`endif
      for (int unsigned i = 0; i < NumSlaves; i++) begin
         if (!found && rule_en_i[i] &&
             (addr_i >= AddrRules[i].start_addr) &&
             (addr_i <  AddrRules[i].end_addr)) begin
            dec_tgt = AddrRules[i].idx[TgtW-1:0];
            found   = 1'b1;
         end
      end
   end

   // Hold off when full, or when switching target with responses pending.
   assign stall = (cnt_q == CntMax) || ((cnt_q != '0) && (dec_tgt != tgt_q));

   // Request routing and grant back to the master; forced low in reset.
   always_comb begin
      slv_req_o = '0;
      gnt_o     = 1'b0;
      if (rst_ni && !stall) begin
         if (dec_tgt == ErrTgt) begin
            gnt_o = req_i;
         end else begin
            for (int unsigned i = 0; i < NumSlaves; i++) begin
               if (dec_tgt == TgtW'(i)) begin
                  slv_req_o[i] = req_i;
                  gnt_o        = slv_gnt_i[i];
               end
            end
         end
      end
   end

   assign grant = req_i & gnt_o;

   // Response selection: only the registered target may answer, and only
   // while something is outstanding.
   always_comb begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
      if (cnt_q != '0) begin
         if (tgt_q == ErrTgt) begin
            rsp_valid = err_rsp_q;
            rsp_data  = err_rsp_q ? ErrData : 32'h0;
         end else begin
            for (int unsigned i = 0; i < NumSlaves; i++) begin
               if (tgt_q == TgtW'(i)) begin
                  rsp_valid = slv_rvalid_i[i];
                  rsp_data  = slv_rdata_i[i*32 +: 32];
               end
            end
         end
      end
   end

   assign rvalid_o = rsp_valid;
   assign rdata_o  = rsp_data;

`ifdef OBI_ADDR_DEMUX_ERR_RESP_EN
   assign err_o = rsp_valid && (tgt_q == ErrTgt);

   // Error target answers exactly one cycle after it grants.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_rsp_q <= 1'b0;
      end else begin
         err_rsp_q <= grant && (dec_tgt == ErrTgt);
      end
   end
`else
   assign err_o     = 1'b0;
   assign err_rsp_q = 1'b0;
`endif

   // Outstanding counter: grant adds one, response removes one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         case ({grant, rsp_valid})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Remember which target owns the outstanding responses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tgt_q <= '0;
      end else if (grant) begin
         tgt_q <= dec_tgt;
      end
   end

endmodule

// File: tb/tb_obi_addr_demux.sv
// tb_obi_addr_demux: directed vectors for obi_addr_demux with the default
// 7-entry map. Inputs change 1 time unit after the rising edge; outputs are
// compared 1 time unit later, well before the next rising edge.

module tb_obi_addr_demux;
   import obi_addr_demux_pkg::*;

   localparam int NS = 7;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NS-1:0]    rule_en;
   logic             req;
   logic             gnt;
   logic [31:0]      addr;
   logic             we;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic             rvalid;
   logic [31:0]      rdata;
   logic             err;
   logic [NS-1:0]    slv_req;
   logic [NS-1:0]    slv_gnt;
   logic [31:0]      slv_addr;
   logic             slv_we;
   logic [3:0]       slv_be;
   logic [31:0]      slv_wdata;
   logic [NS-1:0]    slv_rvalid;
   logic [NS*32-1:0] slv_rdata;

   obi_addr_demux dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .rule_en_i    (rule_en),
      .req_i        (req),
      .gnt_o        (gnt),
      .addr_i       (addr),
      .we_i         (we),
      .be_i         (be),
      .wdata_i      (wdata),
      .rvalid_o     (rvalid),
      .rdata_o      (rdata),
      .err_o        (err),
      .slv_req_o    (slv_req),
      .slv_gnt_i    (slv_gnt),
      .slv_addr_o   (slv_addr),
      .slv_we_o     (slv_we),
      .slv_be_o     (slv_be),
      .slv_wdata_o  (slv_wdata),
      .slv_rvalid_i (slv_rvalid),
      .slv_rdata_i  (slv_rdata)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rd_pat(input int port);
      return 32'hD000_0000 + 32'(port);
   endfunction

   // Response currently on the master port must match the oldest expectation.
   task automatic check_rsp(input string tag);
      logic [31:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
      check({tag, "_rdata"}, rdata, e);
      check({tag, "_err"}, {31'b0, err}, 32'd0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_req(input logic [31:0] a, input logic w);
      req   = 1'b1;
      addr  = a;
      we    = w;
      be    = 4'hF;
      wdata = a ^ 32'h5A5A_A5A5;
   endtask

   // Issue a request that must be granted at once to slave `port`.
   task automatic grant_to(input string tag, input logic [31:0] a, input int port);
      drive_req(a, 1'b0);
      settle();
      check({tag, "_gnt"}, {31'b0, gnt}, 32'd1);
      check({tag, "_slvreq"}, 32'(slv_req), 32'(1) << port);
      exp_q.push_back(rd_pat(port));
      step();
      req = 1'b0;
   endtask

   // Slave `port` answers for one cycle; the answer must reach the master.
   task automatic respond(input string tag, input int port);
      slv_rvalid = NS'(1) << port;
      settle();
      check_rsp(tag);
      step();
      slv_rvalid = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rule_en    = '1;
      req        = 1'b1;
      addr       = 32'h2000_0010;
      we         = 1'b0;
      be         = 4'hF;
      wdata      = '0;
      slv_gnt    = '1;
      slv_rvalid = '0;
      for (int i = 0; i < NS; i++) slv_rdata[i*32 +: 32] = rd_pat(i);

      // Reset state, with a request pending on the master side.
      #2;
      check("rst_gnt", {31'b0, gnt}, 32'd0);
      check("rst_slvreq", 32'(slv_req), 32'd0);
      check("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_cnt", 32'(dut.cnt_q), 32'd0);
      req = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();

      // Write to PERIPH, same-cycle slave grant, response next cycle.
      drive_req(32'h2000_0010, 1'b1);
      settle();
      check("wr_slvreq", 32'(slv_req), 32'h10);
      check("wr_gnt", {31'b0, gnt}, 32'd1);
      check("wr_addr", slv_addr, 32'h2000_0010);
      check("wr_we", {31'b0, slv_we}, 32'd1);
      check("wr_be", {28'b0, slv_be}, 32'hF);
      check("wr_wdata", slv_wdata, 32'h2000_0010 ^ 32'h5A5A_A5A5);
      exp_q.push_back(rd_pat(4));
      step();
      req = 1'b0;
      settle();
      check("wr_cnt1", 32'(dut.cnt_q), 32'd1);
      respond("wr_rsp", 4);
      settle();
      check("wr_cnt0", 32'(dut.cnt_q), 32'd0);
      check("wr_rvalid_off", {31'b0, rvalid}, 32'd0);

      // Unmapped read.
`ifdef OBI_ADDR_DEMUX_ERR_RESP_EN
      drive_req(32'h5000_0000, 1'b0);
      settle();
      check("unm_gnt", {31'b0, gnt}, 32'd1);
      check("unm_slvreq", 32'(slv_req), 32'd0);
      check("unm_rvalid0", {31'b0, rvalid}, 32'd0);
      step();
      req = 1'b0;
      settle();
      check("unm_rvalid", {31'b0, rvalid}, 32'd1);
      check("unm_err", {31'b0, err}, 32'd1);
      check("unm_rdata", rdata, 32'hBADACCE5);
      step();
      check("unm_rvalid_off", {31'b0, rvalid}, 32'd0);
      check("unm_err_off", {31'b0, err}, 32'd0);
      check("unm_cnt0", 32'(dut.cnt_q), 32'd0);
`else
      grant_to("unm", 32'h5000_0000, 0);
      respond("unm_rsp", 0);
      settle();
      check("unm_cnt0", 32'(dut.cnt_q), 32'd0);
`endif

      // Four reads to RAM0 fill the window; the fifth stalls.
      for (int i = 0; i < 4; i++) grant_to("fill", 32'h1000_0100, 1);
      settle();
      check("fill_cnt4", 32'(dut.cnt_q), 32'd4);
      drive_req(32'h1000_0100, 1'b0);
      settle();
      check("full_gnt", {31'b0, gnt}, 32'd0);
      check("full_slvreq", 32'(slv_req), 32'd0);
      step();
      check("full_gnt2", {31'b0, gnt}, 32'd0);
      slv_rvalid = NS'(1) << 1;
      settle();
      check_rsp("full_rsp");
      check("full_gnt3", {31'b0, gnt}, 32'd0);
      step();
      slv_rvalid = '0;
      settle();
      check("full_cnt3", 32'(dut.cnt_q), 32'd3);
      check("full_gnt_now", {31'b0, gnt}, 32'd1);
      exp_q.push_back(rd_pat(1));
      step();
      req = 1'b0;
      settle();
      check("full_cnt4b", 32'(dut.cnt_q), 32'd4);
      for (int i = 0; i < 4; i++) respond("drain", 1);
      settle();
      check("drain_cnt0", 32'(dut.cnt_q), 32'd0);

      // RAM0 outstanding blocks a request to DEBUG.
      grant_to("ram0", 32'h1000_0100, 1);
      drive_req(32'h0000_0100, 1'b0);
      settle();
      check("dbg_blk_gnt", {31'b0, gnt}, 32'd0);
      check("dbg_blk_slvreq", 32'(slv_req), 32'd0);
      step();
      slv_rvalid = NS'(1) << 1;
      settle();
      check_rsp("ram0_rsp");
      check("dbg_blk_gnt2", {31'b0, gnt}, 32'd0);
      step();
      slv_rvalid = '0;
      settle();
      check("dbg_gnt", {31'b0, gnt}, 32'd1);
      check("dbg_slvreq", 32'(slv_req), 32'd1);
      exp_q.push_back(rd_pat(0));
      step();
      req = 1'b0;
      // A stray response from a different port is ignored.
      slv_rvalid = NS'(1) << 3;
      settle();
      check("stray_rvalid", {31'b0, rvalid}, 32'd0);
      step();
      slv_rvalid = '0;
      settle();
      check("stray_cnt1", 32'(dut.cnt_q), 32'd1);
      respond("dbg_rsp", 0);

      // Grant and response in the same cycle leave cnt unchanged.
      grant_to("pair", 32'h1000_0200, 1);
      grant_to("pair", 32'h1000_0200, 1);
      drive_req(32'h1000_0200, 1'b0);
      slv_rvalid = NS'(1) << 1;
      settle();
      check("same_gnt", {31'b0, gnt}, 32'd1);
      check_rsp("same_rsp");
      exp_q.push_back(rd_pat(1));
      step();
      req        = 1'b0;
      slv_rvalid = '0;
      settle();
      check("same_cnt2", 32'(dut.cnt_q), 32'd2);
      respond("pair_rsp", 1);
      respond("pair_rsp", 1);

      // Disabling rule 1 lets the overlapping rule 2 match.
      rule_en[1] = 1'b0;
      grant_to("ovl", 32'h1000_0100, 2);
      // Re-enabling rule 1 only affects new requests.
      rule_en[1] = 1'b1;
      drive_req(32'h1000_0100, 1'b0);
      settle();
      check("ovl_new_gnt", {31'b0, gnt}, 32'd0);
      req = 1'b0;
      respond("ovl_rsp", 2);
      settle();
      check("ovl_cnt0", 32'(dut.cnt_q), 32'd0);

      // Asynchronous reset with three reads outstanding.
      for (int i = 0; i < 3; i++) grant_to("pre_rst", 32'h1000_0100, 1);
      settle();
      check("pre_rst_cnt3", 32'(dut.cnt_q), 32'd3);
      drive_req(32'h1000_0100, 1'b0);
      slv_rvalid = NS'(1) << 1;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_gnt", {31'b0, gnt}, 32'd0);
      check("arst_slvreq", 32'(slv_req), 32'd0);
      check("arst_rvalid", {31'b0, rvalid}, 32'd0);
      check("arst_rdata", rdata, 32'd0);
      check("arst_err", {31'b0, err}, 32'd0);
      check("arst_cnt", 32'(dut.cnt_q), 32'd0);
      exp_q.delete();
      req = 1'b0;
      step();
      rst_n = 1'b1;
      settle();
      check("late_rvalid", {31'b0, rvalid}, 32'd0);
      step();
      slv_rvalid = '0;
      settle();
      check("late_cnt0", 32'(dut.cnt_q), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/obi_addr_demux.md
OBI_ADDR_DEMUX -- requirements
Module: obi_addr_demux

Interface
REQ-001 Parameters SHALL be: NumSlaves, default 7, number of downstream OBI slave ports (1..16).
REQ-002 Parameters SHALL be: MaxOutstanding, default 4, maximum accepted-but-unanswered requests (1..15).
REQ-003 Parameters SHALL be: AddrRules, default 7-entry system map, array [NumSlaves-1:0] of addr_map_rule_t {idx, start_addr, end_addr}.
REQ-004 Parameters SHALL be: ErrData, default 32'hBADACCE5, read data returned for unmapped accesses.
REQ-005 clk_i  input  1  system clock; all state SHALL be on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 rule_en_i  input  NumSlaves  per-rule enable; a disabled rule SHALL never match.
REQ-008 req_i / gnt_o  input / output  1 / 1  master request and grant.
REQ-009 addr_i, we_i, be_i, wdata_i  input  32, 1, 4, 32  master request payload.
REQ-010 rvalid_o, rdata_o, err_o  output  1, 32, 1  master response; err_o qualifies unmapped accesses.
REQ-011 slv_req_o / slv_gnt_i  output / input  NumSlaves / NumSlaves  per-slave request and grant.
REQ-012 slv_addr_o, slv_we_o, slv_be_o, slv_wdata_o  output  32, 1, 4, 32  broadcast payload (copy of master payload).
REQ-013 slv_rvalid_i, slv_rdata_i  input  NumSlaves, NumSlaves*32  per-slave response.

Function
REQ-014 Decode SHALL be combinational: target = idx of lowest-numbered enabled rule with start_addr <= addr_i < end_addr; no match SHALL select the internal error target (code NumSlaves).
REQ-015 State SHALL be: outstanding counter cnt (0..MaxOutstanding), registered target tgt_q, error-response pipeline register.
REQ-016 Request SHALL be stalled (no slv_req_o, gnt_o=0) when cnt==MaxOutstanding, or cnt!=0 and decoded target != tgt_q.
REQ-017 When not stalled, slv_req_o[target]=req_i and gnt_o=slv_gnt_i[target], in the same cycle; all other slv_req_o SHALL be 0.
REQ-018 Error target: gnt_o=req_i same cycle when not stalled; rvalid_o=1, err_o=1, rdata_o=ErrData exactly one cycle after grant.
REQ-019 On req_i & gnt_o, tgt_q SHALL load the decoded target.
REQ-020 rvalid_o/rdata_o SHALL forward slv_rvalid_i[tgt_q]/slv_rdata_i[tgt_q] combinationally when cnt!=0, err_o=0; responses are in order because only one target is outstanding.
REQ-021 cnt: +1 on grant only, -1 on response only, unchanged on grant and response in the same cycle.
REQ-022 cnt SHALL never exceed MaxOutstanding nor underflow; slv_rvalid_i from a non-tgt_q port or with cnt==0 SHALL be ignored.
REQ-023 Changing rule_en_i SHALL affect only new requests; outstanding responses still return via tgt_q.
REQ-024 Zero-latency grant-to-response through the slave path SHALL NOT be assumed; minimum response latency is 1 cycle.

Reset
REQ-025 On rst_ni low: cnt=0, tgt_q=0, error pipeline cleared; gnt_o, rvalid_o, err_o, all slv_req_o=0; rdata_o=0.
REQ-026 Reset mid-transaction SHALL discard all outstanding tracking; late slave responses after reset SHALL be ignored (cnt==0).

Configuration
REQ-027 Macro OBI_ADDR_DEMUX_ERR_RESP_EN: defined -> internal error target per REQ-018; undefined -> unmapped requests SHALL route to slave port 0 as an ordinary target, err_o tied 0.

Verification
REQ-028 Write to 0x2000_0010 with rule 4 mapped there, slave grants same cycle -> slv_req_o[4]=1, gnt_o=1, cnt=1; rvalid next cycle -> cnt=0.
REQ-029 Read 0x5000_0000 (unmapped, macro defined) -> gnt_o same cycle, next cycle rvalid_o=1, err_o=1, rdata_o=0xBADACCE5.
REQ-030 Four back-to-back reads to RAM0, no responses -> 5th request stalled (gnt_o=0) until one rvalid, then granted.
REQ-031 Read to RAM0 outstanding, then request to DEBUG -> stalled until RAM0 rvalid returns, then DEBUG granted.
REQ-032 Grant and rvalid in same cycle with cnt=2 -> cnt stays 2; rule_en_i[1]=0 with overlapping rule -> next rule matches.
REQ-033 rst_ni asserted with cnt=3 -> all outputs 0 immediately; stray slv_rvalid_i after release -> rvalid_o stays 0.
